// File: rtl/sort_stream_oet.sv
// Sequential odd-even transposition sorter: accepts one N-element vector,
// runs N compare-exchange phases (one per clock), then presents the result.
module sort_stream_oet #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic                 in_desc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens at a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid only in DONE, and out_data
  // stays stable while out_valid is high and out_ready is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 desc_q, desc_d;
  logic [N*WIDTH-1:0]   elem_q, elem_d;
  logic [N*WIDTH-1:0]   phase_res;

  // One phase of disjoint compare-exchanges; pairs start at even indices on
  // even phases and odd indices on odd phases, so no pair feeds another.
  always_comb begin
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             swap;
    phase_res = elem_q;
    lo        = '0;
    hi        = '0;
    swap      = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if ((i % 2) == int'(cnt_q[0])) begin
        lo   = elem_q[i*WIDTH +: WIDTH];
        hi   = elem_q[(i+1)*WIDTH +: WIDTH];
        swap = desc_q ? (lo < hi) : (lo > hi);
        if (swap) begin
          phase_res[i*WIDTH +: WIDTH]     = hi;
          phase_res[(i+1)*WIDTH +: WIDTH] = lo;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    desc_d  = desc_q;
    elem_d  = elem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          elem_d  = in_data;
          desc_d  = in_desc;
          cnt_d   = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        elem_d = phase_res;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      desc_q  <= 1'b0;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
      elem_q  <= elem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SORT) || (state_q == DONE);
  assign out_data  = elem_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sort_stream_oet.sv
// Self-checking bench for sort_stream_oet: directed table, hand-written
// multi-cycle sequences, and random vectors against a plain sorting model.
module tb_sort_stream_oet;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int DW = N * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_desc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_tests;
  int n_fail;
  logic [DW-1:0] exp_q[$];

  sort_stream_oet #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_desc   (in_desc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: sort the elements as plain integers.
  function automatic logic [DW-1:0] ref_sort(input logic [DW-1:0] d, input logic desc);
    int a[N];
    int t;
    logic [DW-1:0] r;
    for (int i = 0; i < N; i++) a[i] = int'(d[i*W +: W]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i][W-1:0];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_vector(input string name, input logic [DW-1:0] data,
                            input logic desc, input logic [DW-1:0] exp,
                            input logic toggle_desc);
    int w;
    int lat;
    in_data  = data;
    in_desc  = desc;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 40) begin step(); w++; end
    check({name, " ready_seen"}, DW'(in_ready), DW'(1));
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (toggle_desc) in_desc = ~in_desc;
      step();
      lat++;
    end
    check({name, " latency"}, DW'(lat), DW'(N));
    check({name, " data"}, out_data, exp);
    check({name, " busy_done"}, DW'({busy, in_ready}), DW'(2'b10));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, " post_hs"}, DW'({out_valid, in_ready, busy}), DW'(3'b010));
    check({name, " retained"}, out_data, exp);
  endtask

  typedef struct {
    string         name;
    logic [DW-1:0] data;
    logic          desc;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int out_cyc[3];
    int n_out;
    int n_acc;
    int cyc;
    logic [DW-1:0] b2b[3];
    logic [DW-1:0] held;
    logic [DW-1:0] rv;
    logic          rd;

    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_desc   = 1'b0;
    out_ready = 1'b0;

    tbl[0] = '{"asc_basic",  64'h04_06_02_08_01_07_03_09, 1'b0, 64'h09_08_07_06_04_03_02_01};
    tbl[1] = '{"desc_basic", 64'h04_06_02_08_01_07_03_09, 1'b1, 64'h01_02_03_04_06_07_08_09};
    tbl[2] = '{"dup_ext",    64'hff_00_11_11_00_ff_00_ff, 1'b0, 64'hff_ff_ff_11_11_00_00_00};
    tbl[3] = '{"presorted",  64'h08_07_06_05_04_03_02_01, 1'b0, 64'h08_07_06_05_04_03_02_01};
    tbl[4] = '{"reversed",   64'h01_02_03_04_05_06_07_08, 1'b0, 64'h08_07_06_05_04_03_02_01};
    tbl[5] = '{"rev_desc",   64'h08_07_06_05_04_03_02_01, 1'b1, 64'h01_02_03_04_05_06_07_08};

    step();
    step();
    rst = 1'b0;
    step();
    check("reset_outputs", DW'({out_valid, busy, in_ready}), DW'(3'b001));
    check("reset_data", out_data, '0);

    // Directed table
    foreach (tbl[i]) run_vector(tbl[i].name, tbl[i].data, tbl[i].desc, tbl[i].exp, 1'b0);

    // Direction held while in_desc toggles during SORT
    run_vector("desc_toggle", tbl[1].data, 1'b1, tbl[1].exp, 1'b1);

    // Backpressure in DONE with a stray in_valid pulse
    in_data = tbl[0].data; in_desc = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin step(); cyc++; end
    check("bp_reach_done", DW'(cyc), DW'(N));
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      in_data  = 64'h11_22_33_44_55_66_77_88;
      step();
      check("bp_hold", DW'({out_valid, in_ready}), DW'(2'b10));
      check("bp_data", out_data, tbl[0].exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release", DW'({out_valid, in_ready}), DW'(2'b01));
    check("bp_not_accepted", out_data, tbl[0].exp);

    // Reset mid-sort
    in_data = tbl[2].data; in_desc = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_ctrl", DW'({out_valid, busy, in_ready}), DW'(3'b001));
    check("rst_mid_data", out_data, '0);
    run_vector("after_rst", tbl[2].data, 1'b0, tbl[2].exp, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 3; i++) begin
      for (int e = 0; e < N; e++) b2b[i][e*W +: W] = W'($urandom_range(0, 255));
    end
    n_out = 0; n_acc = 0; cyc = 0;
    out_ready = 1'b1;
    in_desc   = 1'b0;
    in_valid  = 1'b1;
    in_data   = b2b[0];
    while (n_out < 3 && cyc < 200) begin
      if (out_valid) begin
        held = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("b2b_data", out_data, held);
        out_cyc[n_out] = cyc;
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sort(in_data, in_desc));
        n_acc++;
      end
      step();
      cyc++;
      if (n_acc < 3) in_data = b2b[n_acc];
      else in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_outputs", DW'(n_out), DW'(3));
    check("b2b_accepts", DW'(n_acc), DW'(3));
    check("b2b_gap1", DW'(out_cyc[1] - out_cyc[0]), DW'(N + 2));
    check("b2b_gap2", DW'(out_cyc[2] - out_cyc[1]), DW'(N + 2));
    check("b2b_drained", DW'(exp_q.size()), DW'(0));

    // Random vectors, some with a narrow value range to force duplicates
    for (int t = 0; t < 40; t++) begin
      for (int e = 0; e < N; e++)
        rv[e*W +: W] = (t % 3 == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
      rd = 1'($urandom_range(0, 1));
      run_vector("random", rv, rd, ref_sort(rv, rd), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_stream_oet.md
Name: sort_stream_oet

Overview:
- Parametrised sequential sorter. Successor to the fixed 4/8-input combinational sorters.
- Accepts one vector of N unsigned elements through a valid/ready handshake.
- Sorts the vector in place with odd-even transposition, one phase per clock.
- Presents the sorted vector through a valid/ready output handshake. Sort direction is selectable per vector.

Parameters:
- WIDTH, 8, bits per element (>=1); elements are unsigned.
- N, 8, elements per vector; even, >=2.
- CNT_W, $clog2(N+1), width of the phase counter; derived, not overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data and in_desc are valid.
- in_ready  output  1  block can accept a vector; high only in IDLE.
- in_data  input  N*WIDTH  element i = bits [i*WIDTH +: WIDTH].
- in_desc  input  1  0 = ascending (element 0 smallest), 1 = descending; sampled on accept.
- out_valid  output  1  out_data holds a sorted vector.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  N*WIDTH  sorted vector, same element packing as in_data.
- busy  output  1  high in SORT or DONE.

Behaviour:
- Reset (rst=1 at an edge):
  - state = IDLE, phase counter = 0, out_valid = 0, out_data = 0, busy = 0, latched direction = 0.
  - in_ready = 1 in the cycle after reset is released.
  - Reset overrides all other inputs. Reset during SORT or DONE discards the vector with no output.
- States: IDLE, SORT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - Accept when in_valid && in_ready at an edge: load the element register from in_data, latch in_desc, clear the phase counter, go to SORT.
- SORT:
  - One phase per edge.
  - Phase p even: compare-exchange pairs (0,1), (2,3), ..., (N-2,N-1).
  - Phase p odd: compare-exchange pairs (1,2), (3,4), ..., (N-3,N-2). Elements 0 and N-1 are untouched.
  - Ascending: swap a pair (i,i+1) only when elem[i] > elem[i+1].
  - Descending: swap only when elem[i] < elem[i+1].
  - Equal elements are never swapped.
  - Increment the counter each edge. The edge that executes phase N-1 moves the state to DONE.
  - in_valid is ignored; in_ready = 0.
- DONE:
  - out_valid = 1; out_data = element register, held stable until the handshake.
  - On out_valid && out_ready at an edge, go to IDLE; out_valid drops at that edge.
  - out_data retains its value after the handshake. in_ready = 0 in DONE, so input and output never overlap.
- Latency: acceptance at edge k means out_valid is high after edge k+N, i.e. N clocks from accept to first out_valid. With out_ready held high, the next in_ready comes one cycle after the output handshake.
  - Throughput: one vector per N+2 cycles.
- Arithmetic: compares are unsigned, full WIDTH. No widening and no saturation.
- After N phases the result is a fully sorted permutation of the input. Duplicates are preserved with their multiplicity.
- The comparators are combinational within a cycle. Pair compare-exchanges run in parallel (no chained dependencies inside a phase).

Test Plan:
- Ascending, N=8, W=8: in = {9,3,7,1,8,2,6,4} (element 0 first), in_desc=0 -> out_valid 8 cycles after accept; out = {1,2,3,4,6,7,8,9}.
- Descending, same input, in_desc=1 -> out = {9,8,7,6,4,3,2,1}. Direction is held even if in_desc toggles during SORT.
- Duplicates and extremes: in = {255,0,255,0,17,17,0,255}, ascending -> out = {0,0,0,17,17,255,255,255}. Already-sorted and reverse-sorted inputs also sort correctly in exactly N phases.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stay stable; in_ready stays 0; an in_valid pulse is not accepted. Raising out_ready completes the handshake, and in_ready=1 next cycle.
- Reset mid-sort: assert rst at phase 3 -> next cycle out_valid=0, out_data=0, busy=0, in_ready=1. A new vector then sorts correctly.
- Back-to-back: three vectors with in_valid always high and out_ready always high -> each accepted exactly once. Outputs appear in order, spaced N+2 cycles apart.
